// File: rtl/sr_piso_4bit_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word via valid/ready and shifts it out one bit per accepted cycle.
// Latency: first bit visible the cycle after the load edge; back-to-back words stream with no gap (WIDTH cycles per word).
// Backpressure: sout_ready low freezes the word in place; din_ready is combinational from sout_ready at the final bit.
module sr_piso_4bit_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready,
  output logic             busy,
  output logic [7:0]       tx_count
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             bit_acc;
  logic             last_acc;
  logic             load;

  // Handshake decode; din_ready is held low while in reset so nothing loads during reset.
  always_comb begin
    bit_acc   = (state == SHIFT) && sout_ready;
    last_acc  = bit_acc && (cnt == '0);
    din_ready = rst && ((state == IDLE) || last_acc);
    load      = din_valid && din_ready;
  end

  // Next-state logic: a final-bit acceptance either chains straight into a new word or returns to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last_acc) state_nxt = load ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Shift toward the output end with zero fill; direction set by bit order.
  always_comb begin
    shreg_shifted = shreg;
    if (MSB_FIRST) shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    else           shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
  end

  // Datapath: load wins over shifting; the final bit leaves shreg untouched since the output is gated by state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= din;
      cnt   <= CW'(WIDTH - 1);
    end else if (bit_acc && (cnt != '0)) begin
      shreg <= shreg_shifted;
      cnt   <= cnt - CW'(1);
    end
  end

  // Completed-word counter, bumps on each final-bit acceptance and wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          tx_count <= 8'd0;
    else if (last_acc) tx_count <= tx_count + 8'd1;
  end

  // Serial outputs decoded purely from registered state so they are glitch-free toward the receiver.
  always_comb begin
    sout_valid = (state == SHIFT);
    busy       = sout_valid;
    sout_last  = sout_valid && (cnt == '0);
    sout       = sout_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  end

endmodule

// File: tb/tb_sr_piso_4bit_tx.sv
// Directed bench for sr_piso_4bit_tx: MSB-first instance plus an LSB-first instance sharing the same inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Each scenario task carries its own inline comparisons and hand-computed expected values.
module tb_sr_piso_4bit_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       sout_ready;

  logic       din_ready,   din_ready_l;
  logic       sout,        sout_l;
  logic       sout_valid,  sout_valid_l;
  logic       sout_last,   sout_last_l;
  logic       busy,        busy_l;
  logic [7:0] tx_count,    tx_count_l;

  int         total_cnt;
  int         pass_cnt;
  logic [7:0] exp_tx;

  sr_piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .sout_ready(sout_ready),
    .busy(busy), .tx_count(tx_count)
  );

  sr_piso_4bit_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .sout_last(sout_last_l), .sout_ready(sout_ready),
    .busy(busy_l), .tx_count(tx_count_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 4'h0; din_valid = 1'b0; sout_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total_cnt++;
    if ({sout, sout_valid, sout_last, busy, din_ready} !== 5'b00000) begin
      $display("FAIL reset_outputs: got %b expected 00000", {sout, sout_valid, sout_last, busy, din_ready});
    end else pass_cnt++;
    total_cnt++;
    if (tx_count !== 8'd0) $display("FAIL reset_tx_count: got %0d expected 0", tx_count);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (din_ready !== 1'b1) $display("FAIL reset_release_din_ready: got %b expected 1", din_ready);
    else pass_cnt++;
    exp_tx = 8'd0;
  endtask

  task automatic test_basic_msb();
    logic [3:0] exp_bits;
    exp_bits = 4'b0101;
    din = 4'b0101; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({sout, sout_valid, sout_last} !== {exp_bits[3-i], 1'b1, (i == 3)}) begin
        $display("FAIL basic_bit%0d: got sout/vld/last=%b expected %b", i, {sout, sout_valid, sout_last},
                 {exp_bits[3-i], 1'b1, (i == 3)});
      end else pass_cnt++;
      tick();
    end
    exp_tx = exp_tx + 8'd1;
    @(negedge clk);
    total_cnt++;
    if ({sout_valid, busy} !== 2'b00) $display("FAIL basic_idle: got vld/busy=%b expected 00", {sout_valid, busy});
    else pass_cnt++;
    total_cnt++;
    if (tx_count !== exp_tx) $display("FAIL basic_tx_count: got %0d expected %0d", tx_count, exp_tx);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    exp_bits = 8'b0011_1101;
    din = 4'b0011; din_valid = 1'b1;
    tick();
    din = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({sout, sout_valid, sout_last, din_ready} !== {exp_bits[7-i], 1'b1, (i % 4 == 3), (i % 4 == 3)}) begin
        $display("FAIL b2b_bit%0d: got sout/vld/last/rdy=%b expected %b", i,
                 {sout, sout_valid, sout_last, din_ready},
                 {exp_bits[7-i], 1'b1, (i % 4 == 3), (i % 4 == 3)});
      end else pass_cnt++;
      tick();
      if (i == 3) din_valid = 1'b0;
    end
    exp_tx = exp_tx + 8'd2;
    @(negedge clk);
    total_cnt++;
    if ({sout_valid, tx_count} !== {1'b0, exp_tx}) begin
      $display("FAIL b2b_end: got vld=%b tx_count=%0d expected vld=0 tx_count=%0d", sout_valid, tx_count, exp_tx);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_stall();
    logic [6:0] rdy;
    logic [6:0] exp_sout;
    logic [6:0] exp_last;
    rdy      = 7'b1100011;
    exp_sout = 7'b1100001;
    exp_last = 7'b0000001;
    din = 4'b1101; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sout_ready = rdy[6-i];
      @(negedge clk);
      total_cnt++;
      if ({sout, sout_valid, sout_last} !== {exp_sout[6-i], 1'b1, exp_last[6-i]}) begin
        $display("FAIL stall_cycle%0d: got sout/vld/last=%b expected %b", i, {sout, sout_valid, sout_last},
                 {exp_sout[6-i], 1'b1, exp_last[6-i]});
      end else pass_cnt++;
      tick();
    end
    sout_ready = 1'b1;
    exp_tx = exp_tx + 8'd1;
    @(negedge clk);
    total_cnt++;
    if ({sout_valid, tx_count} !== {1'b0, exp_tx}) begin
      $display("FAIL stall_end: got vld=%b tx_count=%0d expected vld=0 tx_count=%0d", sout_valid, tx_count, exp_tx);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_ignored_load();
    logic [3:0] exp_bits;
    exp_bits = 4'b0110;
    din = 4'b0110; din_valid = 1'b1;
    tick();
    din = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      din_valid = (i < 2);
      @(negedge clk);
      total_cnt++;
      if ({sout, sout_last, din_ready} !== {exp_bits[3-i], (i == 3), (i == 3)}) begin
        $display("FAIL ignore_bit%0d: got sout/last/rdy=%b expected %b", i, {sout, sout_last, din_ready},
                 {exp_bits[3-i], (i == 3), (i == 3)});
      end else pass_cnt++;
      tick();
    end
    exp_tx = exp_tx + 8'd1;
    @(negedge clk);
    total_cnt++;
    if ({sout_valid, tx_count} !== {1'b0, exp_tx}) begin
      $display("FAIL ignore_end: got vld=%b tx_count=%0d expected vld=0 tx_count=%0d", sout_valid, tx_count, exp_tx);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] exp_bits;
    din = 4'b0111; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({sout, sout_valid, sout_last, busy, din_ready, tx_count} !== {5'b00000, 8'd0}) begin
      $display("FAIL midreset_outputs: got sout/vld/last/busy/rdy=%b tx_count=%0d expected 00000 and 0",
               {sout, sout_valid, sout_last, busy, din_ready}, tx_count);
    end else pass_cnt++;
    exp_tx = 8'd0;
    tick();
    tick();
    rst = 1'b1;
    exp_bits = 4'b0101;
    din = 4'b0101; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({sout, sout_valid, sout_last} !== {exp_bits[3-i], 1'b1, (i == 3)}) begin
        $display("FAIL midreset_reload_bit%0d: got sout/vld/last=%b expected %b", i,
                 {sout, sout_valid, sout_last}, {exp_bits[3-i], 1'b1, (i == 3)});
      end else pass_cnt++;
      tick();
    end
    exp_tx = exp_tx + 8'd1;
    @(negedge clk);
    total_cnt++;
    if (tx_count !== exp_tx) $display("FAIL midreset_tx_count: got %0d expected %0d", tx_count, exp_tx);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    din = 4'b0101; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({sout_l, sout_valid_l, sout_last_l} !== {exp_seq[3-i], 1'b1, (i == 3)}) begin
        $display("FAIL lsb_bit%0d: got sout/vld/last=%b expected %b", i,
                 {sout_l, sout_valid_l, sout_last_l}, {exp_seq[3-i], 1'b1, (i == 3)});
      end else pass_cnt++;
      tick();
    end
    exp_tx = exp_tx + 8'd1;
    tick();
  endtask

  task automatic test_counter_wrap();
    int n;
    int gaps;
    n = 256 - int'(exp_tx);
    gaps = 0;
    din = 4'b1001; din_valid = 1'b1;
    tick();
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w == n - 1 && b == 3) din_valid = 1'b0;
        @(negedge clk);
        if (sout_valid !== 1'b1) gaps++;
        if (w == n - 1 && b == 3) begin
          total_cnt++;
          if (tx_count !== 8'd255) $display("FAIL wrap_pre: got %0d expected 255", tx_count);
          else pass_cnt++;
        end
        tick();
      end
    end
    total_cnt++;
    if (gaps !== 0) $display("FAIL wrap_gaps: got %0d idle cycles expected 0", gaps);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({sout_valid, tx_count} !== {1'b0, 8'd0}) begin
      $display("FAIL wrap_end: got vld=%b tx_count=%0d expected vld=0 tx_count=0", sout_valid, tx_count);
    end else pass_cnt++;
    tick();
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    exp_tx    = 8'd0;
    test_reset();
    test_basic_msb();
    test_back_to_back();
    test_stall();
    test_ignored_load();
    test_reset_mid_word();
    test_lsb_first();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sr_piso_4bit_tx.md
# sr_piso_4bit_tx

Parallel-in serial-out transmitter that sits at the opposite end of the team's 4-bit parallel shift-register datapath. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per accepted cycle. A downstream ready input provides back-pressure. The output framing marks the final bit of each word so that a receiving shift register can reassemble it.

## Interface
- WIDTH, 4, word width in bits (≥2)
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-low
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept din this cycle
- sout  output  1  current serial bit
- sout_valid  output  1  sout carries a valid bit
- sout_last  output  1  sout is the final bit of the current word
- sout_ready  input  1  downstream accepts sout this cycle
- busy  output  1  a word is in flight (equals sout_valid)
- tx_count  output  8  count of completed words, wraps modulo 256

## Operation
- Internal state: FSM {IDLE, SHIFT}, shift register shreg[WIDTH-1:0], bit counter cnt[$clog2(WIDTH)-1:0], and tx_count.
- Load: a word transfers on a rising edge where din_valid && din_ready. shreg <= din, cnt <= WIDTH-1, state <= SHIFT.
- din_ready = rst && (state==IDLE || (state==SHIFT && cnt==0 && sout_ready)). This path is combinational from sout_ready.
- In SHIFT, sout_valid=1. sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]. sout_last = (cnt==0).
- A bit is accepted on a rising edge where sout_valid && sout_ready.
  - Accepted bit with cnt≠0: shreg shifts toward the output end with zero fill, and cnt decrements.
  - Accepted bit with cnt==0: tx_count increments. If din_valid is also high, the next word loads on the same edge with no idle gap. Otherwise state <= IDLE.
- sout_ready low in SHIFT: shreg, cnt, sout, sout_valid and sout_last all hold.
- din_valid while busy and not at an accepted final bit: ignored. din is not captured and no error is raised.
- In IDLE: sout=0, sout_valid=0, sout_last=0.
- sout_ready in IDLE has no effect.
- Signals are registered except din_ready: sout, sout_valid, sout_last, busy and tx_count are decoded only from state, shreg, cnt and tx_count.

## Timing
- Reset (rst low, asynchronous): state=IDLE, shreg=0, cnt=0, tx_count=0.
- Outputs during reset: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=0.
- din_ready returns to 1 combinationally once rst deasserts.
- Load latency: for a word accepted at edge N, the first bit appears on sout after edge N (visible in cycle N+1).
- Throughput with sout_ready held high: one bit per cycle. Back-to-back words stream with no gap, i.e. WIDTH cycles per word.
- Stall: each low cycle of sout_ready adds exactly one cycle to the word.
- Reset mid-word aborts the word immediately, with no partial tx_count increment. After release, the block behaves as if fresh from power-up.
- tx_count increments on the final-bit acceptance edge and wraps from 255 to 0.
- Load and final-bit acceptance on the same edge: tx_count increments and the new word loads together.

## Test plan
- Reset, then MSB_FIRST=1, sout_ready=1, load 4'b0101.
  - Required: sout = 0,1,0,1 over 4 consecutive cycles; sout_last high only on the 4th bit; then IDLE with sout_valid=0; tx_count=1.
- Back-to-back: din_valid held high with 4'b0011 then 4'b1101, sout_ready=1.
  - Required: 8 contiguous bits 0,0,1,1,1,1,0,1; din_ready pulses on the 4th-bit cycle; no idle cycle between words; tx_count=2.
- Stall: load 4'b1101, drop sout_ready for 3 cycles after the 2nd bit is accepted.
  - Required: sout=0 (3rd bit) and sout_valid=1 held for all 3 cycles; the word completes in 7 cycles; sout_last appears only on the 4th bit.
- Ignored load: while busy mid-word with cnt≠0, present din_valid=1 with 4'b1111.
  - Required: din_ready=0; the current word is unaltered; 4'b1111 is not sent unless still presented at the final bit.
- Reset mid-word: pull rst low after the 2nd bit of 4'b0111.
  - Required: all outputs go to their reset values immediately; tx_count=0; a subsequent load of 4'b0101 transmits cleanly.
- MSB_FIRST=0: load 4'b0101.
  - Required: sout = 1,0,1,0.
- Counter wrap: stream 256 words.
  - Required: tx_count returns to 0.
